// File: rtl/fp16_norm_arbiter.sv
// Round-robin arbiter feeding one shared FP16 normalize stage from two requesters.
// Classifies the selected word, tags issued operands and stalls the stage on consumer backpressure.
module fp16_norm_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [15:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [15:0]      req1_data,
    output logic             req1_ready,
    output logic             norm_enable,
    output logic             norm_s_valid,
    output logic             norm_sign,
    output logic [4:0]       norm_exp,
    output logic [9:0]       norm_mant,
    output logic             norm_is_normal,
    output logic             norm_is_subnormal,
    output logic             norm_is_nan,
    output logic             norm_is_pinf,
    output logic             norm_is_ninf,
    input  logic             norm_n_valid,
    output logic             resp_valid,
    output logic             resp_id,
    input  logic             resp_ready,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic             primed_reg;
    logic             last_grant_reg;
    logic             tag_reg;
    logic [CNT_W-1:0] cnt_reg [2];
    logic [1:0]       gnt;
    logic [1:0]       req_valid;
    logic [15:0]      sel_data;
    logic             stall;

    assign req_valid = {req1_valid, req0_valid};

    // primed masks the normalize stage's unreset valid flop for the first cycle out of reset
    always_comb begin
        resp_valid  = primed_reg & norm_n_valid;
        stall       = resp_valid & ~resp_ready;
        norm_enable = ~stall;
    end

    always_comb begin
        gnt = 2'b00;
        if (primed_reg && norm_enable) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_reg) gnt = 2'b01;
                else                gnt = 2'b10;
            end else if (req0_valid) begin
                gnt = 2'b01;
            end else if (req1_valid) begin
                gnt = 2'b10;
            end
        end
    end

    assign req0_ready   = gnt[0];
    assign req1_ready   = gnt[1];
    assign norm_s_valid = |(gnt & req_valid);
    assign sel_data     = gnt[1] ? req1_data : req0_data;
    assign norm_sign    = sel_data[15];
    assign norm_exp     = sel_data[14:10];
    assign norm_mant    = sel_data[9:0];
    assign resp_id      = tag_reg;
    assign gnt_cnt0     = cnt_reg[0];
    assign gnt_cnt1     = cnt_reg[1];

    always_comb begin
        norm_is_normal    = 1'b0;
        norm_is_subnormal = 1'b0;
        norm_is_nan       = 1'b0;
        norm_is_pinf      = 1'b0;
        norm_is_ninf      = 1'b0;
        if (norm_exp == 5'd31) begin
            if (norm_mant != 10'd0) norm_is_nan  = 1'b1;
            else if (!norm_sign)    norm_is_pinf = 1'b1;
            else                    norm_is_ninf = 1'b1;
        end else if (norm_exp == 5'd0) begin
            norm_is_subnormal = 1'b1;
        end else begin
            norm_is_normal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
            tag_reg        <= 1'b0;
        end else begin
            primed_reg <= 1'b1;
            if (norm_s_valid) begin
                last_grant_reg <= gnt[1];
                tag_reg        <= gnt[1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                       cnt_reg[gi] <= '0;
                else if (gnt[gi] && req_valid[gi]) cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

endmodule

// File: tb/tb_fp16_norm_arbiter.sv
// Scoreboard bench: issue checks push expected resp_id; a negedge monitor pops on each handshake.
module tb_fp16_norm_arbiter;

    localparam int CNT_W = 16;
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_NORM = 5'b10000;
    localparam logic [4:0] C_SUB  = 5'b01000;
    localparam logic [4:0] C_NAN  = 5'b00100;
    localparam logic [4:0] C_PINF = 5'b00010;
    localparam logic [4:0] C_NINF = 5'b00001;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_data, req1_data;
    logic norm_enable, norm_s_valid, norm_sign;
    logic [4:0] norm_exp;
    logic [9:0] norm_mant;
    logic norm_is_normal, norm_is_subnormal, norm_is_nan, norm_is_pinf, norm_is_ninf;
    logic norm_n_valid = 1'b1;
    logic resp_valid, resp_id, resp_ready;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int mon_e;

    always #5 clk = ~clk;

    fp16_norm_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .norm_enable(norm_enable), .norm_s_valid(norm_s_valid),
        .norm_sign(norm_sign), .norm_exp(norm_exp), .norm_mant(norm_mant),
        .norm_is_normal(norm_is_normal), .norm_is_subnormal(norm_is_subnormal),
        .norm_is_nan(norm_is_nan), .norm_is_pinf(norm_is_pinf), .norm_is_ninf(norm_is_ninf),
        .norm_n_valid(norm_n_valid),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_ready(resp_ready),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // Model of the normalize stage's valid flop: no reset, powers up set
    always @(posedge clk) if (norm_enable) norm_n_valid <= norm_s_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every consumer handshake must match the oldest issued tag
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_id: unexpected result id=%0d, required none", resp_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_id", {31'd0, resp_id}, mon_e[31:0]);
            end
        end
    end

    task automatic step(input logic v0, input logic [15:0] d0, input logic v1, input logic [15:0] d1,
                        input logic rr, input logic er0, input logic er1,
                        input logic [4:0] ecls, input logic een);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        resp_ready = rr;
        @(negedge clk);
        chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, er1, er0});
        chk("enable", {31'd0, norm_enable}, {31'd0, een});
        if (ecls != C_NONE)
            chk("class", {27'd0, norm_is_normal, norm_is_subnormal, norm_is_nan, norm_is_pinf, norm_is_ninf},
                {27'd0, ecls});
        if (er0 || er1) begin
            chk("s_valid", {31'd0, norm_s_valid}, 32'd1);
            exp_q.push_back(er1 ? 1 : 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = 16'h0;
        req1_valid = 1'b0; req1_data = 16'h0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_enable", {31'd0, norm_enable}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_s_valid", {31'd0, norm_s_valid}, 32'd0);
        chk("rst_cnt", {gnt_cnt1, gnt_cnt0}, 32'd0);

        // first cycle out of reset: not yet primed, no grant
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 16'h3C00;
        @(negedge clk);
        chk("unprimed_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("unprimed_resp", {31'd0, resp_valid}, 32'd0);

        step(0, 16'h0, 0, 16'h0, 1, 0, 0, C_NONE, 1);
        chk("idle_resp", {31'd0, resp_valid}, 32'd0);
        repeat (3) step(1, 16'h3C00, 0, 16'h0, 1, 1, 0, C_NORM, 1);
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, C_NONE, 1);
        chk("cnt0_after3", {16'd0, gnt_cnt0}, 32'd3);

        // both valid: last grant was 0, so rotation starts at 1
        for (int i = 0; i < 2; i++) begin
            step(1, 16'h3C00, 1, 16'h0001, 1, 0, 1, C_SUB, 1);
            step(1, 16'h3C00, 1, 16'h0001, 1, 1, 0, C_NORM, 1);
        end
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, C_NONE, 1);
        chk("cnt_rr", {gnt_cnt1, gnt_cnt0}, {16'd2, 16'd5});

        // stall: issue with consumer not ready, hold four cycles
        step(1, 16'h3C00, 0, 16'h0, 0, 1, 0, C_NORM, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 16'h3C00, 1, 16'h4000, 0, 0, 0, C_NONE, 0);
            chk("stall_resp", {30'd0, resp_valid, resp_id}, {30'd0, 1'b1, 1'b0});
        end
        step(1, 16'h3C00, 1, 16'h4000, 1, 0, 1, C_NORM, 1);
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, C_NONE, 1);

        // classification sweep through requester 1
        step(0, 16'h0, 1, 16'h7E00, 1, 0, 1, C_NAN, 1);
        step(0, 16'h0, 1, 16'h7C00, 1, 0, 1, C_PINF, 1);
        step(0, 16'h0, 1, 16'hFC00, 1, 0, 1, C_NINF, 1);
        step(0, 16'h0, 1, 16'h0001, 1, 0, 1, C_SUB, 1);
        step(0, 16'h0, 1, 16'h8000, 1, 0, 1, C_SUB, 1);
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, C_NONE, 1);

        // reset while a stalled result is pending
        step(0, 16'h0, 1, 16'h3C00, 0, 0, 1, C_NORM, 1);
        step(0, 16'h0, 0, 16'h0, 0, 0, 0, C_NONE, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("async_enable", {31'd0, norm_enable}, 32'd1);
        chk("async_cnt", {gnt_cnt1, gnt_cnt0}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("reprime_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        step(1, 16'h3C00, 1, 16'h4000, 1, 1, 0, C_NORM, 1);
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, C_NONE, 1);
        chk("cnt_after_rst", {gnt_cnt1, gnt_cnt0}, {16'd0, 16'd1});
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
